cfg_write_arbiter: RTL and testbench
====================================

Name: cfg_write_arbiter

Overview:
Shares the single write port of the configuration register (8-bit config with mode field [1:0] and enable bit [2]) among NUM_REQ requesters.
- Arbitration is round-robin.
- A mirror (shadow) of the programmed value is kept.
- Mode changes while the block is enabled are rejected. To change mode safely, software disables, re-modes, then re-enables.
- Sits between the software/sequence agents and the config register's wr_en/wr_data inputs.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, config word width
MODE_LSB, 0, LSB of mode field
MODE_W, 2, mode field width
EN_BIT, 2, bit index of enable

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester write request
req_data  in  NUM_REQ*DATA_W  per-requester write data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-cycle completion pulse to the granted requester
resp_err  out  1  qualifies the req_ready pulse: 1 = rejected, no write done
cfg_wr_en  out  1  write strobe to config register
cfg_wr_data  out  DATA_W  write data to config register
cfg_shadow  out  DATA_W  value currently programmed in config register
grant_id  out  $clog2(NUM_REQ)  index of requester being served (valid while busy)
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready=0, resp_err=0, cfg_wr_en=0, cfg_wr_data=0, busy=0, grant_id=0.
  - cfg_shadow=8'h00, matching the config register's reset value.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, CHECK, WRITE, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last+1 upward with wrap.
  - Capture its req_data, set grant_id, set last=winner, busy=1, go to CHECK.
  - Otherwise stay in IDLE.
- CHECK (one cycle):
  - illegal = shadow[EN_BIT] & data[EN_BIT] & (data mode field != shadow mode field).
  - Legal: go to WRITE.
  - Illegal: go to RESP with err flag set.
- WRITE:
  - cfg_wr_en=1 and cfg_wr_data=captured data for exactly this cycle.
  - cfg_shadow takes the captured data at the end of this cycle.
  - Go to RESP.
- RESP:
  - req_ready[grant_id]=1 for exactly this cycle; resp_err = err flag.
  - Go to IDLE with busy=0.
  - A new grant can therefore be made in the cycle after RESP.
- Latency, with valid first seen in IDLE at cycle T:
  - Legal request: cfg_wr_en at T+2, req_ready at T+3.
  - Rejected request: req_ready with resp_err=1 at T+2, no cfg_wr_en.
  - Throughput: one request per 4 cycles (legal) or 3 cycles (rejected).
- Handshake:
  - Requesters hold valid and data until their req_ready.
  - Data is captured at grant; later changes or a dropped valid do not affect the transaction in flight.
  - The block samples req_valid only in IDLE.
  - A requester that keeps valid high after its ready is treated as a new request; round-robin ensures the others are served first.
- Legality rules:
  - Disabling (data[EN_BIT]=0) is always legal.
  - Enabling from disabled with any mode is legal.
  - Rewriting the identical value while enabled is legal and still performs the write.
  - Bits outside the mode and enable fields are never checked.
- Simultaneous requests: exactly one is granted; the others stay pending and are served in round-robin order.
- Reset mid-operation: the transaction is aborted with no req_ready pulse. All outputs and the shadow return to reset values on the next edge.
- Only one req_ready bit is ever high, and never in the same cycle as cfg_wr_en.

Test Plan:
- Reset release with req_valid[0]=1, data=8'h05 -> cfg_wr_en at T+2 with cfg_wr_data=8'h05; req_ready=4'b0001 and resp_err=0 at T+3; cfg_shadow=8'h05.
- Shadow=8'h05, then requester 1 writes 8'h06 (mode change while enabled) -> no cfg_wr_en; req_ready=4'b0010, resp_err=1 at T+2; shadow stays 8'h05.
- Shadow=8'h05: write 8'h00, then 8'h02, then 8'h06 -> all three accepted; shadow ends at 8'h06.
- All four req_valid held high with distinct data, after reset -> grant order 0,1,2,3,0; one req_ready pulse every 4 cycles; no requester is starved.
- Requester 2 drops valid and changes data one cycle after grant -> the originally captured data is written and req_ready[2] still pulses.
- rst asserted in WRITE state -> next cycle cfg_wr_en=0, busy=0, no req_ready pulse, cfg_shadow=8'h00, next grant goes to requester 0.

Source files
------------

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter sharing the config register write port among NUM_REQ requesters.
// Keeps a shadow of the programmed value and rejects mode changes while enabled.
module cfg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MODE_LSB = 0,
  parameter int MODE_W   = 2,
  parameter int EN_BIT   = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_err,
  output logic                      cfg_wr_en,
  output logic [DATA_W-1:0]         cfg_wr_data,
  output logic [DATA_W-1:0]         cfg_shadow,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]  capData_q, capData_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;

  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               respErr_q, respErr_d;
  logic               wrEn_q, wrEn_d;
  logic [DATA_W-1:0]  wrData_q, wrData_d;
  logic               busy_q, busy_d;

  logic               anyReq;
  logic               illegal;
  logic               hiFound, loFound;
  logic [IDW-1:0]     hiIdx, loIdx, winner;
  logic [DATA_W-1:0]  winData;

  assign anyReq  = |req_valid;
  assign illegal = shadow_q[EN_BIT] & capData_q[EN_BIT] &
                   (capData_q[MODE_LSB +: MODE_W] != shadow_q[MODE_LSB +: MODE_W]);

  // Round-robin: lowest requester above the last winner, else lowest overall (wrap).
  always_comb begin
    hiFound = 1'b0;
    loFound = 1'b0;
    hiIdx   = '0;
    loIdx   = '0;
    winData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > int'(last_q)) begin
          if (!hiFound) begin
            hiFound = 1'b1;
            hiIdx   = IDW'(i);
          end
        end else if (!loFound) begin
          loFound = 1'b1;
          loIdx   = IDW'(i);
        end
      end
    end
    winner = hiFound ? hiIdx : loIdx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        winData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (anyReq) state_d = CHECK;
      CHECK:   state_d = illegal ? RESP : WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context: captured at grant so later requester changes cannot leak in.
  always_comb begin
    last_d    = last_q;
    grant_d   = grant_q;
    capData_d = capData_q;
    err_d     = err_q;
    shadow_d  = shadow_q;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          last_d    = winner;
          grant_d   = winner;
          capData_d = winData;
          err_d     = 1'b0;
        end
      end
      CHECK:   err_d    = illegal;
      WRITE:   shadow_d = capData_q;
      default: ;
    endcase
  end

  // Outputs are decoded from the upcoming state so every port comes straight from a flop.
  always_comb begin
    wrEn_d    = (state_d == WRITE);
    wrData_d  = wrEn_d ? capData_q : '0;
    busy_d    = (state_d != IDLE);
    respErr_d = (state_d == RESP) & err_d;
    ready_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_d[i] = (state_d == RESP) && (grant_q == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= IDW'(NUM_REQ - 1);
      grant_q   <= '0;
      capData_q <= '0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
      ready_q   <= '0;
      respErr_q <= 1'b0;
      wrEn_q    <= 1'b0;
      wrData_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      grant_q   <= grant_d;
      capData_q <= capData_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      ready_q   <= ready_d;
      respErr_q <= respErr_d;
      wrEn_q    <= wrEn_d;
      wrData_q  <= wrData_d;
      busy_q    <= busy_d;
    end
  end

  assign req_ready   = ready_q;
  assign resp_err    = respErr_q;
  assign cfg_wr_en   = wrEn_q;
  assign cfg_wr_data = wrData_q;
  assign cfg_shadow  = shadow_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Testbench for cfg_write_arbiter: directed vector table, corner-case sequences and
// randomized requesters checked against a transaction-level reference model.
module tb_cfg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          resp_err;
  logic          cfg_wr_en;
  logic [DW-1:0] cfg_wr_data;
  logic [DW-1:0] cfg_shadow;
  logic [1:0]    grant_id;
  logic          busy;

  cfg_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_err    (resp_err),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_data (cfg_wr_data),
    .cfg_shadow  (cfg_shadow),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ready;
    logic       err;
    logic       wrEn;
    logic [7:0] wrData;
    logic [7:0] shadow;
    logic       busy;
    logic [1:0] grant;
  } outs_t;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    outs_t       exp;
  } vec_t;

  int    vecCount  = 0;
  int    missCount = 0;
  int    cycleNo   = 0;
  vec_t  tbl[$];

  // Reference model: each grant expands into a queue of per-cycle expected outputs.
  logic [7:0] mShadow;
  int         mLast;
  logic [1:0] mGrant;
  outs_t      expQ[$];

  function automatic outs_t mkOut(logic [3:0] rd, logic er, logic we, logic [7:0] wd,
                                  logic [7:0] sh, logic bz, logic [1:0] gr);
    outs_t o;
    o.ready  = rd;
    o.err    = er;
    o.wrEn   = we;
    o.wrData = wd;
    o.shadow = sh;
    o.busy   = bz;
    o.grant  = gr;
    return o;
  endfunction

  function automatic outs_t modelStep(logic r, logic [3:0] v, logic [31:0] d);
    int         w;
    int         idx;
    logic [7:0] dat;
    logic       legal;
    logic [3:0] oneHot;
    if (r) begin
      expQ.delete();
      mShadow = 8'h00;
      mLast   = N - 1;
      mGrant  = 2'd0;
      return mkOut(4'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    end
    if (expQ.size() == 0) begin
      if (v == 4'b0) return mkOut(4'b0, 1'b0, 1'b0, 8'h00, mShadow, 1'b0, mGrant);
      w = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (mLast + k) % N;
        if (w < 0 && v[idx]) w = idx;
      end
      dat    = d[w*8 +: 8];
      legal  = !(mShadow[2] && dat[2] && (dat[1:0] != mShadow[1:0]));
      mLast  = w;
      mGrant = 2'(w);
      oneHot = 4'(1 << w);
      expQ.push_back(mkOut(4'b0, 1'b0, 1'b0, 8'h00, mShadow, 1'b1, mGrant));
      if (legal) begin
        expQ.push_back(mkOut(4'b0, 1'b0, 1'b1, dat, mShadow, 1'b1, mGrant));
        mShadow = dat;
        expQ.push_back(mkOut(oneHot, 1'b0, 1'b0, 8'h00, mShadow, 1'b1, mGrant));
      end else begin
        expQ.push_back(mkOut(oneHot, 1'b1, 1'b0, 8'h00, mShadow, 1'b1, mGrant));
      end
      expQ.push_back(mkOut(4'b0, 1'b0, 1'b0, 8'h00, mShadow, 1'b0, mGrant));
    end
    return expQ.pop_front();
  endfunction

  task automatic checkOutput(input outs_t exp, input string name);
    outs_t act;
    act = mkOut(req_ready, resp_err, cfg_wr_en, cfg_wr_data, cfg_shadow, busy, grant_id);
    if (!exp.busy) begin
      act.grant = 2'd0;
      exp.grant = 2'd0;
    end
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s cycle %0d: got ready=%b err=%b we=%b wd=%h sh=%h busy=%b gid=%0d, expected ready=%b err=%b we=%b wd=%h sh=%h busy=%b gid=%0d",
               name, cycleNo, act.ready, act.err, act.wrEn, act.wrData, act.shadow, act.busy, act.grant,
               exp.ready, exp.err, exp.wrEn, exp.wrData, exp.shadow, exp.busy, exp.grant);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d);
    outs_t exp;
    rst       = r;
    req_valid = v;
    req_data  = d;
    @(posedge clk);
    exp = modelStep(r, v, d);
    cycleNo++;
    #1;
    checkOutput(exp, "model");
  endtask

  function automatic void addVec(logic r, logic [3:0] v, logic [31:0] d, outs_t e);
    vec_t t;
    t.rst   = r;
    t.valid = v;
    t.data  = d;
    t.exp   = e;
    tbl.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         grants[$];
    int         stamps[$];
    int         exp5[5];
    bit         sawWr, sawReady;
    logic [3:0] aValid;
    logic [7:0] aData[4];
    logic [31:0] d;
    bit         rr;

    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Reset release, accepted write, rejected mode change, disable/re-mode/re-enable.
    addVec(1, 4'b0001, 32'h0000_0005, mkOut(4'b0000, 0, 0, 8'h00, 8'h00, 0, 0));
    addVec(0, 4'b0001, 32'h0000_0005, mkOut(4'b0000, 0, 0, 8'h00, 8'h00, 1, 0));
    addVec(0, 4'b0001, 32'h0000_0005, mkOut(4'b0000, 0, 1, 8'h05, 8'h00, 1, 0));
    addVec(0, 4'b0001, 32'h0000_0005, mkOut(4'b0001, 0, 0, 8'h00, 8'h05, 1, 0));
    addVec(0, 4'b0000, 32'h0000_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h05, 0, 0));
    addVec(0, 4'b0010, 32'h0000_0600, mkOut(4'b0000, 0, 0, 8'h00, 8'h05, 1, 1));
    addVec(0, 4'b0010, 32'h0000_0600, mkOut(4'b0010, 1, 0, 8'h00, 8'h05, 1, 1));
    addVec(0, 4'b0000, 32'h0000_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h05, 0, 1));
    addVec(0, 4'b0100, 32'h0000_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h05, 1, 2));
    addVec(0, 4'b0100, 32'h0000_0000, mkOut(4'b0000, 0, 1, 8'h00, 8'h05, 1, 2));
    addVec(0, 4'b0100, 32'h0000_0000, mkOut(4'b0100, 0, 0, 8'h00, 8'h00, 1, 2));
    addVec(0, 4'b0100, 32'h0002_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h00, 0, 2));
    addVec(0, 4'b0100, 32'h0002_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h00, 1, 2));
    addVec(0, 4'b0100, 32'h0002_0000, mkOut(4'b0000, 0, 1, 8'h02, 8'h00, 1, 2));
    addVec(0, 4'b0100, 32'h0002_0000, mkOut(4'b0100, 0, 0, 8'h00, 8'h02, 1, 2));
    addVec(0, 4'b0100, 32'h0006_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h02, 0, 2));
    addVec(0, 4'b0100, 32'h0006_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h02, 1, 2));
    addVec(0, 4'b0100, 32'h0006_0000, mkOut(4'b0000, 0, 1, 8'h06, 8'h02, 1, 2));
    addVec(0, 4'b0100, 32'h0006_0000, mkOut(4'b0100, 0, 0, 8'h00, 8'h06, 1, 2));
    addVec(0, 4'b0000, 32'h0000_0000, mkOut(4'b0000, 0, 0, 8'h00, 8'h06, 0, 2));

    $display("[TB] directed vector table");
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].data);
      checkOutput(tbl[i].exp, $sformatf("table[%0d]", i));
    end

    // All four requesters held high: order 0,1,2,3,0 with one completion every 4 cycles.
    $display("[TB] fairness sequence");
    applyStimulus(1, 4'b0000, 32'h0);
    for (int c = 0; c < 40 && grants.size() < 5; c++) begin
      applyStimulus(0, 4'b1111, 32'h4433_2211);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          grants.push_back(i);
          stamps.push_back(cycleNo);
        end
      end
    end
    checkValue("fair_count", grants.size(), 5);
    exp5 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5 && i < grants.size(); i++) begin
      checkValue($sformatf("fair_order[%0d]", i), grants[i], exp5[i]);
      if (i > 0) checkValue($sformatf("fair_gap[%0d]", i), stamps[i] - stamps[i-1], 4);
    end

    // Requester 2 drops valid and changes data right after its grant.
    $display("[TB] capture-at-grant sequence");
    applyStimulus(1, 4'b0000, 32'h0);
    applyStimulus(0, 4'b0100, 32'h0001_0000);
    sawWr = 0;
    sawReady = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 4'b0000, 32'h0007_0000);
      if (cfg_wr_en && cfg_wr_data == 8'h01) sawWr = 1;
      if (req_ready == 4'b0100) sawReady = 1;
    end
    checkValue("captured_write", int'(sawWr), 1);
    checkValue("dropped_ready", int'(sawReady), 1);
    checkValue("captured_shadow", int'(cfg_shadow), 8'h01);

    // Reset while in WRITE aborts the transaction and restarts round-robin at 0.
    $display("[TB] reset-in-write sequence");
    applyStimulus(1, 4'b0000, 32'h0);
    applyStimulus(0, 4'b0001, 32'h0000_0005);
    applyStimulus(0, 4'b0001, 32'h0000_0005);
    checkValue("write_before_reset", int'(cfg_wr_en), 1);
    applyStimulus(1, 4'b0001, 32'h0000_0005);
    checkValue("abort_wr_en", int'(cfg_wr_en), 0);
    checkValue("abort_busy", int'(busy), 0);
    checkValue("abort_ready", int'(req_ready), 0);
    checkValue("abort_shadow", int'(cfg_shadow), 0);
    applyStimulus(0, 4'b0011, 32'h0000_0901);
    checkValue("post_reset_grant", int'(grant_id), 0);
    checkValue("post_reset_busy", int'(busy), 1);
    for (int c = 0; c < 3; c++) applyStimulus(0, 4'b0011, 32'h0000_0901);
    for (int c = 0; c < 6; c++) applyStimulus(0, 4'b0000, 32'h0);

    // Randomized requesters that hold valid/data until served.
    $display("[TB] random sequence");
    applyStimulus(1, 4'b0000, 32'h0);
    aValid = '0;
    for (int i = 0; i < N; i++) aData[i] = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      rr = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!aValid[i] && $urandom_range(0, 2) == 0) begin
          aValid[i] = 1'b1;
          aData[i]  = 8'($urandom_range(0, 255));
        end
      end
      d = {aData[3], aData[2], aData[1], aData[0]};
      applyStimulus(rr, aValid, d);
      if (rr) begin
        aValid = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            aValid[i] = ($urandom_range(0, 3) == 0);
            aData[i]  = 8'($urandom_range(0, 255));
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
